reg_bank_p8: RTL and testbench

REG_BANK_P8 -- requirements
Module: reg_bank_p8

---
 rtl/reg_bank_p8.sv | 67 ++++++
 tb/tb_reg_bank_p8.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_p8.sv
// Eight 8-bit registers loaded by a 12-bit instruction stream; an illegal opcode
// locks the bank into a cleared ERROR state that only reset can leave.
module reg_bank_p8 (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic [7:0]  out_0,
    output logic [7:0]  out_1,
    output logic [7:0]  out_2,
    output logic [7:0]  out_3,
    output logic [7:0]  out_4,
    output logic [7:0]  out_5,
    output logic [7:0]  out_6,
    output logic [7:0]  out_7,
    output logic        state_dbg
);

    typedef enum logic {
        READY = 1'b0,
        ERROR = 1'b1
    } state_t;

    // Handshake: inst is consumed on a rising edge only when inst_en=1 and the
    // bank is READY; there is no back-pressure, so every accepted word executes.

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD7 = 4'h8;

    state_t      state;
    logic [7:0]  regs [8];
    logic [3:0]  opcode;
    logic [3:0]  op_minus_one;
    logic [2:0]  target;

    assign opcode       = inst[11:8];
    assign op_minus_one = opcode - 4'd1;
    assign target       = op_minus_one[2:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= READY;
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (state == READY && inst_en) begin
            if (opcode == OP_NOP) begin
                state <= READY;
            end else if (opcode <= OP_LD7) begin
                regs[target] <= inst[7:0];
            end else begin
                // Illegal opcode: clear at the same edge that enters ERROR.
                state <= ERROR;
                for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            end
        end
    end

    assign out_0     = regs[0];
    assign out_1     = regs[1];
    assign out_2     = regs[2];
    assign out_3     = regs[3];
    assign out_4     = regs[4];
    assign out_5     = regs[5];
    assign out_6     = regs[6];
    assign out_7     = regs[7];
    assign state_dbg = (state == ERROR);

endmodule

// File: tb/tb_reg_bank_p8.sv
// Directed bench for reg_bank_p8: a behavioural register-file model checked every
// falling edge, plus literal expectations taken straight from the requirement list.
module tb_reg_bank_p8;

    logic        clock;
    logic        reset;
    logic [11:0] inst;
    logic        inst_en;
    logic [7:0]  out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
    logic        state_dbg;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 0;

    // behavioural model: an array of eight bytes and an error flag
    logic [7:0] m_regs [8];
    bit         m_err;

    reg_bank_p8 dut (
        .clock     (clock),
        .reset     (reset),
        .inst      (inst),
        .inst_en   (inst_en),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_4     (out_4),
        .out_5     (out_5),
        .out_6     (out_6),
        .out_7     (out_7),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_err = 0;
    end

    always @(negedge reset) begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_err = 0;
    end

    always @(posedge clock) begin
        int op;
        op = int'(inst[11:8]);
        if (reset === 1'b1 && inst_en === 1'b1 && !m_err) begin
            if (op >= 1 && op <= 8) begin
                m_regs[op - 1] = inst[7:0];
            end else if (op >= 9) begin
                m_err = 1;
                for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            end
        end
    end

    function automatic logic [7:0] out_of(input int i);
        case (i)
            0: return out_0;
            1: return out_1;
            2: return out_2;
            3: return out_3;
            4: return out_4;
            5: return out_5;
            6: return out_6;
            default: return out_7;
        endcase
    endfunction

    // compare process: every falling edge once the bench has done its first reset
    always @(negedge clock) begin
        logic [64:0] act;
        logic [64:0] exp;
        if (cmp_on) begin
            act = {out_7, out_6, out_5, out_4, out_3, out_2, out_1, out_0, state_dbg};
            exp = {m_regs[7], m_regs[6], m_regs[5], m_regs[4],
                   m_regs[3], m_regs[2], m_regs[1], m_regs[0], m_err};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp);
            end
        end
    end

    // driver: present an instruction, return just after the edge that captures it
    task automatic issue(input logic en, input logic [11:0] word);
        inst    = word;
        inst_en = en;
        @(posedge clock);
        #1;
        inst_en = 1'b0;
    endtask

    task automatic check_reg(input string name, input int idx, input logic [7:0] want);
        logic [7:0] got;
        got = out_of(idx);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s out_%0d got=%h expected=%h", name, idx, got, want);
        end
    endtask

    task automatic check_state(input string name, input logic want);
        n_vec++;
        if (state_dbg !== want) begin
            n_err++;
            $display("FAIL %s state_dbg got=%b expected=%b", name, state_dbg, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 8; i++) check_reg(name, i, 8'h00);
    endtask

    logic [7:0] ld_data [8];
    logic [7:0] snap [8];

    initial begin
        ld_data[0] = 8'hBA; ld_data[1] = 8'hFE; ld_data[2] = 8'h23; ld_data[3] = 8'h43;
        ld_data[4] = 8'h12; ld_data[5] = 8'hEA; ld_data[6] = 8'hFE; ld_data[7] = 8'hAB;

        reset   = 1'b0;
        inst    = 12'h000;
        inst_en = 1'b0;
        #12;
        check_all_zero("reset_hold");
        check_state("reset_hold", 1'b0);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        cmp_on = 1;

        // LD0..LD7 back to back, each visible right after its edge
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, {4'(i + 1), ld_data[i]});
            check_reg("ld_seq", i, ld_data[i]);
            if (i < 7) check_reg("ld_seq_next_untouched", i + 1, 8'h00);
        end
        for (int i = 0; i < 8; i++) check_reg("ld_all", i, ld_data[i]);

        // NOP with unknown data
        for (int i = 0; i < 8; i++) snap[i] = out_of(i);
        issue(1'b1, {4'h0, 8'bxxxx_xxxx});
        for (int i = 0; i < 8; i++) begin
            check_reg("nop_x", i, ld_data[i]);
            n_vec++;
            if ($isunknown(out_of(i)) || out_of(i) !== snap[i]) begin
                n_err++;
                $display("FAIL nop_x_known out_%0d got=%h expected=%h", i, out_of(i), snap[i]);
            end
        end

        // disabled load is ignored, enabled one lands
        issue(1'b0, 12'h287);
        check_reg("ld_disabled", 1, 8'hFE);
        issue(1'b1, 12'h1AE);
        check_reg("ld0_ae", 0, 8'hAE);
        check_reg("ld0_ae_others", 1, 8'hFE);
        check_reg("ld0_ae_others", 7, 8'hAB);

        // illegal opcode without enable does nothing
        issue(1'b0, 12'hF12);
        check_state("illegal_disabled", 1'b0);
        check_reg("illegal_disabled", 2, 8'h23);
        issue(1'b1, 12'h355);
        check_reg("ld2_55", 2, 8'h55);

        // overwrite the same register twice in a row
        issue(1'b1, 12'h801);
        issue(1'b1, 12'h8C3);
        check_reg("ld7_overwrite", 7, 8'hC3);

        // illegal opcode with enable: clear and lock
        issue(1'b1, 12'hFAB);
        check_all_zero("error_clear");
        check_state("error_enter", 1'b1);
        issue(1'b1, 12'h227);
        check_reg("error_ignore", 1, 8'h00);
        issue(1'b1, 12'h9FF);
        check_state("error_sticky", 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check_state("error_sticky_idle", 1'b1);

        // asynchronous reset between edges, with a load presented during reset
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        check_state("async_reset", 1'b0);
        inst    = 12'h477;
        inst_en = 1'b1;
        @(posedge clock);
        #1;
        inst_en = 1'b0;
        check_reg("reset_override", 3, 8'h00);
        reset = 1'b1;
        issue(1'b1, 12'h11A);
        check_reg("post_reset_ld0", 0, 8'h1A);
        check_state("post_reset", 1'b0);
        issue(1'b1, 12'h0FF);
        check_reg("post_reset_nop", 0, 8'h1A);

        // reset from READY mid-operation
        issue(1'b1, 12'h566);
        check_reg("ld4_66", 4, 8'h66);
        #3;
        reset = 1'b0;
        #1;
        check_reg("ready_reset", 4, 8'h00);
        check_reg("ready_reset", 0, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b1;
        issue(1'b1, 12'h6A5);
        check_reg("ld5_after_reset", 5, 8'hA5);

        repeat (2) @(posedge clock);
        #1;
        cmp_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
